// File: rtl/seq_muldiv8.sv
// rtl/seq_muldiv8.sv - iterative 8-bit unsigned shift-add multiplier / restoring divider
module seq_muldiv8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Op,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] High,
    output logic             Ovf,
    output logic             Error
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             op_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q, ovf_q, error_q;
    logic [WIDTH-1:0] result_q, high_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] hi_d, lo_d;

    // hi/lo hold {partial product, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        hi_d      = mul_sum[WIDTH:1];
        lo_d      = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (op_q) begin
            hi_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
            high_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= Op;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (Op && (B == '0)) begin
                            error_q  <= 1'b1;
                            result_q <= '1;
                            high_q   <= A;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            hi_q    <= '0;
                            lo_q    <= Op ? A : B;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        result_q <= lo_d;
                        high_q   <= hi_d;
                        ovf_q    <= ~op_q & (|hi_d);
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;
    assign High   = high_q;
    assign Ovf    = ovf_q;
    assign Error  = error_q;

endmodule

// File: tb/tb_seq_muldiv8.sv
// tb/tb_seq_muldiv8.sv - randomized and directed bench for seq_muldiv8 against a behavioural model
module tb_seq_muldiv8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A, B;
    logic       Op, Start;
    logic       Busy, Done, Ovf, Error;
    logic [7:0] Result, High;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    seq_muldiv8 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Op(Op), .Start(Start),
        .Busy(Busy), .Done(Done), .Result(Result), .High(High), .Ovf(Ovf), .Error(Error)
    );

    always #5 clk = ~clk;

    // Model: m_rem counts cycles left until back in idle; results commit when it reaches 1
    int         m_rem = 0;
    logic [7:0] m_res = 0, m_high = 0, p_res = 0, p_high = 0;
    logic       m_ovf = 0, m_err = 0, p_ovf = 0;
    logic [15:0] prod;

    always @(posedge clk) begin
        if (rst) begin
            m_rem = 0; m_res = 0; m_high = 0; m_ovf = 0; m_err = 0;
        end else if (m_rem == 0) begin
            if (Start) begin
                m_ovf = 0;
                m_err = 0;
                if (Op && B == 0) begin
                    m_res = 8'hFF; m_high = A; m_err = 1; m_rem = 1;
                end else begin
                    if (!Op) begin
                        prod   = 16'(A) * 16'(B);
                        p_res  = prod[7:0];
                        p_high = prod[15:8];
                        p_ovf  = (prod > 16'd255);
                    end else begin
                        p_res  = A / B;
                        p_high = A % B;
                        p_ovf  = 0;
                    end
                    m_rem = 9;
                end
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 1) begin
                m_res = p_res; m_high = p_high; m_ovf = p_ovf;
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   16'(Busy),   16'(m_rem != 0));
            check("done",   16'(Done),   16'(m_rem == 1));
            check("result", 16'(Result), 16'(m_res));
            check("high",   16'(High),   16'(m_high));
            check("ovf",    16'(Ovf),    16'(m_ovf));
            check("error",  16'(Error),  16'(m_err));
        end
    end

    task automatic run_op(input string tag, input logic op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic [7:0] eh, input logic eo, input logic ee,
                          input int elat);
        int n;
        bit seen;
        @(negedge clk);
        Op = op; A = a; B = b; Start = 1;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            Start = 0; A = 8'($urandom); B = 8'($urandom); Op = 1'($urandom);
            if (Done) seen = 1;
        end
        check({tag, " done seen"}, 16'(seen), 16'd1);
        check({tag, " latency"}, 16'(n), 16'(elat));
        check({tag, " result"}, 16'(Result), 16'(er));
        check({tag, " high"}, 16'(High), 16'(eh));
        check({tag, " ovf"}, 16'(Ovf), 16'(eo));
        check({tag, " error"}, 16'(Error), 16'(ee));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dcnt, d1, d2, n;
        rst = 1; A = 0; B = 0; Op = 0; Start = 0;
        @(negedge clk); @(negedge clk);
        check("reset busy", 16'(Busy), 16'd0);
        check("reset done", 16'(Done), 16'd0);
        check("reset result", 16'(Result), 16'd0);
        check("reset high", 16'(High), 16'd0);
        check("reset flags", 16'({Ovf, Error}), 16'd0);
        rst = 0;
        chk_en = 1;

        run_op("mul13x11", 0, 8'd13, 8'd11, 8'h8F, 8'h00, 0, 0, 9);
        run_op("mul200x3", 0, 8'd200, 8'd3, 8'h58, 8'h02, 1, 0, 9);
        run_op("mul255x255", 0, 8'd255, 8'd255, 8'h01, 8'hFE, 1, 0, 9);
        run_op("div200/7", 1, 8'd200, 8'd7, 8'h1C, 8'h04, 0, 0, 9);
        run_op("div5/9", 1, 8'd5, 8'd9, 8'h00, 8'h05, 0, 0, 9);
        run_op("div5/0", 1, 8'd5, 8'd0, 8'hFF, 8'h05, 0, 1, 1);
        run_op("mul after div0", 0, 8'd2, 8'd3, 8'h06, 8'h00, 0, 0, 9);

        // Reset sampled at the fourth edge of a 13*11 run
        @(negedge clk);
        Op = 0; A = 8'd13; B = 8'd11; Start = 1;
        dcnt = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            Start = 0;
            if (Done) dcnt++;
            if (i == 4) rst = 1;
            if (i == 5) begin
                check("midrst busy", 16'(Busy), 16'd0);
                check("midrst result", 16'(Result), 16'd0);
                check("midrst high", 16'(High), 16'd0);
                rst = 0;
            end
        end
        check("midrst no done", 16'(dcnt), 16'd0);

        // Start pulses during run are ignored; Start held through DONE is taken one edge later
        @(negedge clk);
        Op = 0; A = 8'd13; B = 8'd11; Start = 1;
        dcnt = 0; d1 = 0; d2 = 0;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            Start = (i == 3) || (i >= 8 && i <= 10);
            if (Done) begin
                dcnt++;
                if (dcnt == 1) d1 = i;
                if (dcnt == 2) d2 = i;
            end
            if (i == 10) check("idle after done", 16'(Busy), 16'd0);
        end
        check("ignored start done count", 16'(dcnt), 16'd2);
        check("first done cycle", 16'(d1), 16'd9);
        check("held start done cycle", 16'(d2), 16'd19);

        for (int k = 0; k < 300; k++) begin
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) @(negedge clk);
            @(negedge clk);
            Op = 1'($urandom);
            A = 8'($urandom);
            B = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            Start = 1;
            for (int j = 0; j < 12; j++) begin
                @(negedge clk);
                Start = ($urandom_range(0, 7) == 0);
                A = 8'($urandom); B = 8'($urandom); Op = 1'($urandom);
                rst = ($urandom_range(0, 99) == 0);
            end
            Start = 0;
            rst = 0;
            n = 0;
            while (Busy && n < 12) begin
                @(negedge clk);
                n++;
            end
            check("random drain idle", 16'(Busy), 16'd0);
        end

        @(negedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
